obi_apb_arbiter: RTL and testbench

- Round-robin arbiter that shares one OBI-to-APB bridge between NumReq OBI managers, e.g. the core data port, a debug module and a DMA.
- It sits between the requesters and the bridge's OBI subordinate port.
- It admits one transaction at a time and holds that lock from request through response.
- It routes the grant and the response back to the winning requester only.

---
 rtl/obi_apb_arbiter.sv | 166 ++++++++++++++++
 tb/tb_obi_apb_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_apb_arbiter.sv
// Round-robin arbiter sharing one OBI-to-APB bridge between NumReq OBI managers.
// One transaction is admitted at a time and stays locked from request through response.
// Grant and response are routed only to the winning requester.
module obi_apb_arbiter #(
    parameter int unsigned NumReq = 2,
    parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumReq-1:0]      s_req_i,
    output logic [NumReq-1:0]      s_gnt_o,
    input  logic [NumReq*32-1:0]   s_addr_i,
    input  logic [NumReq-1:0]      s_we_i,
    input  logic [NumReq*4-1:0]    s_be_i,
    input  logic [NumReq*32-1:0]   s_wdata_i,
    output logic [NumReq-1:0]      s_rvalid_o,
    output logic [31:0]            s_rdata_o,
    output logic                   s_err_o,
    output logic                   m_req_o,
    input  logic                   m_gnt_i,
    output logic [31:0]            m_addr_o,
    output logic                   m_we_o,
    output logic [3:0]             m_be_o,
    output logic [31:0]            m_wdata_o,
    input  logic                   m_rvalid_i,
    input  logic [31:0]            m_rdata_i,
    input  logic                   m_err_i,
    output logic                   busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        RESP
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0] winner;
    logic [IdxW-1:0] nxt_ptr;
    logic [IdxW:0]   cand;
    logic            found;

    // Unpacked views of the packed per-requester request buses
    logic [31:0] addr_arr  [NumReq];
    logic [31:0] wdata_arr [NumReq];
    logic [3:0]  be_arr    [NumReq];

    for (genvar k = 0; k < NumReq; k++) begin : g_unpack
        assign addr_arr[k]  = s_addr_i[32*k +: 32];
        assign wdata_arr[k] = s_wdata_i[32*k +: 32];
        assign be_arr[k]    = s_be_i[4*k +: 4];
    end

    // Round-robin search: first requester at or after rr_ptr_q, wrapping by explicit compare
    always_comb begin
        winner = rr_ptr_q;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = {1'b0, rr_ptr_q} + (IdxW+1)'(i);
            if (cand >= (IdxW+1)'(NumReq)) begin
                cand = cand - (IdxW+1)'(NumReq);
            end
            if (!found && s_req_i[cand[IdxW-1:0]]) begin
                winner = cand[IdxW-1:0];
                found  = 1'b1;
            end
        end
    end

    // Pointer moves just past the requester that was served; wrap by compare, not overflow
    always_comb begin
        if (idx_q == IdxW'(NumReq - 1)) begin
            nxt_ptr = '0;
        end else begin
            nxt_ptr = idx_q + IdxW'(1);
        end
    end

    // State, winner index and round-robin pointer registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, wait for gnt in FWD, wait for rvalid in RESP
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (|s_req_i) begin
                    idx_d   = winner;
                    state_d = FWD;
                end
            end
            FWD: begin
                if (m_gnt_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (m_rvalid_i) begin
                    rr_ptr_d = nxt_ptr;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: request mux only in FWD, response routing only in RESP
    always_comb begin
        s_gnt_o    = '0;
        s_rvalid_o = '0;
        s_rdata_o  = '0;
        s_err_o    = 1'b0;
        m_req_o    = 1'b0;
        m_addr_o   = '0;
        m_we_o     = 1'b0;
        m_be_o     = '0;
        m_wdata_o  = '0;
        busy_o     = (state_q != IDLE);
        unique case (state_q)
            FWD: begin
                m_req_o        = 1'b1;
                m_addr_o       = addr_arr[idx_q];
                m_we_o         = s_we_i[idx_q];
                m_be_o         = be_arr[idx_q];
                m_wdata_o      = wdata_arr[idx_q];
                s_gnt_o[idx_q] = m_gnt_i;
            end
            RESP: begin
                s_rvalid_o[idx_q] = m_rvalid_i;
                s_rdata_o         = m_rdata_i;
                s_err_o           = m_err_i;
            end
            default: begin
            end
        endcase
    end

    // The winner must keep req high until it is granted
    a_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == FWD) |-> s_req_i[idx_q]);

    // Bridge handshakes outside their expected phase are ignored and flagged
    a_gnt_in_fwd: assert property (@(posedge clk_i) disable iff (!rst_ni)
        m_gnt_i |-> (state_q == FWD));

    a_rvalid_in_resp: assert property (@(posedge clk_i) disable iff (!rst_ni)
        m_rvalid_i |-> (state_q == RESP));

endmodule

// File: tb/tb_obi_apb_arbiter.sv
// Bench for obi_apb_arbiter with three requesters and a simple bridge responder.
// A transaction-level model predicts every output on each falling clock edge.
module tb_obi_apb_arbiter;

    localparam int unsigned N = 3;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [N-1:0]      s_req_i;
    logic [N-1:0]      s_gnt_o;
    logic [N*32-1:0]   s_addr_i;
    logic [N-1:0]      s_we_i;
    logic [N*4-1:0]    s_be_i;
    logic [N*32-1:0]   s_wdata_i;
    logic [N-1:0]      s_rvalid_o;
    logic [31:0]       s_rdata_o;
    logic              s_err_o;
    logic              m_req_o;
    logic              m_gnt_i;
    logic [31:0]       m_addr_o;
    logic              m_we_o;
    logic [3:0]        m_be_o;
    logic [31:0]       m_wdata_o;
    logic              m_rvalid_i;
    logic [31:0]       m_rdata_i;
    logic              m_err_i;
    logic              busy_o;

    obi_apb_arbiter #(.NumReq(N)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .s_req_i    (s_req_i),
        .s_gnt_o    (s_gnt_o),
        .s_addr_i   (s_addr_i),
        .s_we_i     (s_we_i),
        .s_be_i     (s_be_i),
        .s_wdata_i  (s_wdata_i),
        .s_rvalid_o (s_rvalid_o),
        .s_rdata_o  (s_rdata_o),
        .s_err_o    (s_err_o),
        .m_req_o    (m_req_o),
        .m_gnt_i    (m_gnt_i),
        .m_addr_o   (m_addr_o),
        .m_we_o     (m_we_o),
        .m_be_o     (m_be_o),
        .m_wdata_o  (m_wdata_o),
        .m_rvalid_i (m_rvalid_i),
        .m_rdata_i  (m_rdata_i),
        .m_err_i    (m_err_i),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Bridge responder knobs and state
    int unsigned gnt_wait  = 1;
    int unsigned rv_wait   = 0;
    logic [31:0] bfm_rdata = '0;
    logic        bfm_err   = 1'b0;
    logic        rnd_mode  = 1'b1;
    logic        rnd_gnt   = 1'b0;
    logic        rnd_rv    = 1'b0;
    int unsigned wcnt, rcnt;
    logic        resp_pend;
    logic        bfm_gnt;

    assign bfm_gnt    = m_req_o && (wcnt >= gnt_wait);
    assign m_gnt_i    = bfm_gnt | rnd_gnt;
    assign m_rvalid_i = (resp_pend && (rcnt >= rv_wait)) | rnd_rv;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wcnt      <= 0;
            rcnt      <= 0;
            resp_pend <= 1'b0;
        end else begin
            if (m_req_o && !bfm_gnt) wcnt <= wcnt + 1;
            else                     wcnt <= 0;
            if (m_req_o && bfm_gnt) begin
                resp_pend <= 1'b1;
                rcnt      <= 0;
            end else if (resp_pend) begin
                if (m_rvalid_i) resp_pend <= 1'b0;
                else            rcnt <= rcnt + 1;
            end
        end
    end

    // Requesters: rem[k] transactions still to issue, seq[k] numbers their payloads
    int unsigned rem [N];
    int unsigned seq [N];
    logic [N-1:0] we_cfg = '0;

    always @(posedge clk_i) begin
        #2;
        if (rnd_mode) begin
            s_req_i   = N'($urandom);
            s_we_i    = N'($urandom);
            s_be_i    = (N*4)'($urandom);
            s_addr_i  = {$urandom, $urandom, $urandom};
            s_wdata_i = {$urandom, $urandom, $urandom};
            rnd_gnt   = 1'($urandom);
            rnd_rv    = 1'($urandom);
            m_rdata_i = $urandom;
            m_err_i   = 1'($urandom);
        end else begin
            rnd_gnt   = 1'b0;
            rnd_rv    = 1'b0;
            m_rdata_i = bfm_rdata;
            m_err_i   = bfm_err;
            for (int k = 0; k < N; k++) begin
                s_req_i[k]          = (rem[k] != 0);
                s_we_i[k]           = we_cfg[k];
                s_be_i[4*k +: 4]    = 4'(4'h3 << k);
                s_addr_i[32*k +: 32]  = 32'h0000_1000 + 32'(k * 256) + 32'(seq[k] * 4);
                s_wdata_i[32*k +: 32] = 32'hA000_0000 | 32'(k << 16) | 32'(seq[k]);
            end
        end
    end

    // Transaction-level model: cur = requester holding the lock (-1 none), granted = past gnt
    int cur = -1;
    int ptr = 0;
    bit granted = 1'b0;
    int order [$];

    function automatic int pick(input logic [N-1:0] req, input int p);
        for (int i = 0; i < N; i++) begin
            if (req[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    always @(negedge clk_i) begin
        logic [N-1:0] e_gnt, e_rv;
        logic [31:0]  e_addr, e_wdata, e_rdata;
        logic [3:0]   e_be;
        logic         e_req, e_we, e_err, e_busy;
        e_gnt = '0; e_rv = '0; e_addr = '0; e_wdata = '0; e_rdata = '0;
        e_be = '0; e_req = 1'b0; e_we = 1'b0; e_err = 1'b0; e_busy = 1'b0;
        if (!rst_ni) begin
            cur = -1;
            ptr = 0;
            granted = 1'b0;
        end else if (cur >= 0) begin
            e_busy = 1'b1;
            if (!granted) begin
                e_req   = 1'b1;
                e_addr  = s_addr_i[cur*32 +: 32];
                e_wdata = s_wdata_i[cur*32 +: 32];
                e_be    = s_be_i[cur*4 +: 4];
                e_we    = s_we_i[cur];
                if (m_gnt_i) e_gnt[cur] = 1'b1;
            end else begin
                e_rdata = m_rdata_i;
                e_err   = m_err_i;
                if (m_rvalid_i) e_rv[cur] = 1'b1;
            end
        end
        chk("s_gnt_o",    32'(s_gnt_o),    32'(e_gnt));
        chk("s_rvalid_o", 32'(s_rvalid_o), 32'(e_rv));
        chk("s_rdata_o",  s_rdata_o,       e_rdata);
        chk("s_err_o",    32'(s_err_o),    32'(e_err));
        chk("m_req_o",    32'(m_req_o),    32'(e_req));
        chk("m_addr_o",   m_addr_o,        e_addr);
        chk("m_we_o",     32'(m_we_o),     32'(e_we));
        chk("m_be_o",     32'(m_be_o),     32'(e_be));
        chk("m_wdata_o",  m_wdata_o,       e_wdata);
        chk("busy_o",     32'(busy_o),     32'(e_busy));
        if (rst_ni) begin
            if (cur < 0) begin
                cur = pick(s_req_i, ptr);
                granted = 1'b0;
                if (cur >= 0) order.push_back(cur);
            end else if (!granted) begin
                if (m_gnt_i) granted = 1'b1;
            end else if (m_rvalid_i) begin
                ptr = (cur + 1) % N;
                cur = -1;
            end
            for (int k = 0; k < N; k++) begin
                if (s_gnt_o[k]) begin
                    rem[k] = rem[k] - 1;
                    seq[k] = seq[k] + 1;
                end
            end
        end
    end

    task automatic wait_all(input int budget);
        bit done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk_i);
            if (rem[0] == 0 && rem[1] == 0 && rem[2] == 0 && !busy_o) done = 1'b1;
        end
        chk("wait_all_timeout", 32'(done), 32'd1);
    endtask

    // Counts falling edges from the first cycle the request is visible; records gnt/rvalid cycles
    task automatic measure(input int k, output int gc, output int rc, output logic [31:0] rd,
                           output logic er, output logic mr, output logic [31:0] a1,
                           output logic other_rv);
        gc = -1; rc = -1; rd = '0; er = 1'b0; mr = 1'b1; a1 = '0; other_rv = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            if (c == 1) a1 = m_addr_o;
            if (s_gnt_o[k] && gc < 0) gc = c;
            if (s_rvalid_o[k] && rc < 0) begin
                rc = c; rd = s_rdata_o; er = s_err_o; mr = m_req_o;
            end
            for (int j = 0; j < N; j++) if (j != k && s_rvalid_o[j]) other_rv = 1'b1;
        end
    endtask

    int          gc, rc;
    logic [31:0] rd, a1;
    logic        er, mr, orv;
    int          exp4 [9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};

    initial begin
        for (int k = 0; k < N; k++) begin rem[k] = 0; seq[k] = 0; end
        s_req_i = '0; s_we_i = '0; s_be_i = '0; s_addr_i = '0; s_wdata_i = '0;
        m_rdata_i = '0; m_err_i = 1'b0;

        // 1: reset with random inputs, every output must be 0
        repeat (3) begin
            @(negedge clk_i);
            chk("rst_busy",   32'(busy_o),     32'd0);
            chk("rst_m_req",  32'(m_req_o),    32'd0);
            chk("rst_gnt",    32'(s_gnt_o),    32'd0);
            chk("rst_rdata",  s_rdata_o,       32'd0);
        end
        @(posedge clk_i); #1 rnd_mode = 1'b0;
        @(posedge clk_i); #1 rst_ni = 1'b1;

        // 3: simultaneous writes from reset, requester 0 first then 1
        we_cfg = 3'b011;
        order.delete();
        @(negedge clk_i);
        rem[0] = 1; rem[1] = 1;
        wait_all(200);
        chk("t3_count",  32'(order.size()), 32'd2);
        chk("t3_first",  32'(order[0]),     32'd0);
        chk("t3_second", 32'(order[1]),     32'd1);

        // 2: single read from requester 0
        we_cfg = 3'b000;
        bfm_rdata = 32'hDEAD_BEEF;
        @(negedge clk_i);
        rem[0] = 1;
        measure(0, gc, rc, rd, er, mr, a1, orv);
        chk("t2_gnt_cycle",    32'(gc), 32'd2);
        chk("t2_rvalid_cycle", 32'(rc), 32'd3);
        chk("t2_rdata",        rd,      32'hDEAD_BEEF);
        chk("t2_err",          32'(er), 32'd0);
        chk("t2_mreq_in_resp", 32'(mr), 32'd0);
        chk("t2_addr",         a1,      32'h0000_1004);

        // 5: error response with three extra wait cycles on requester 1
        gnt_wait = 4; bfm_err = 1'b1; bfm_rdata = 32'h0BAD_0001;
        @(negedge clk_i);
        rem[1] = 1;
        measure(1, gc, rc, rd, er, mr, a1, orv);
        chk("t5_gnt_cycle",    32'(gc),  32'd5);
        chk("t5_rvalid_cycle", 32'(rc),  32'd6);
        chk("t5_err",          32'(er),  32'd1);
        chk("t5_other_rvalid", 32'(orv), 32'd0);
        gnt_wait = 1; bfm_err = 1'b0;

        // 6: reset while the response is pending, then a clean transaction
        rv_wait = 2; bfm_rdata = 32'h1234_5678;
        @(negedge clk_i);
        rem[2] = 1;
        begin
            bit seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(negedge clk_i);
                if (s_gnt_o[2]) seen = 1'b1;
            end
            chk("t6_gnt_seen", 32'(seen), 32'd1);
        end
        @(posedge clk_i); #1;
        chk("t6_busy_before", 32'(busy_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("t6_busy_after",   32'(busy_o),     32'd0);
        chk("t6_mreq_after",   32'(m_req_o),    32'd0);
        chk("t6_rvalid_after", 32'(s_rvalid_o), 32'd0);
        rv_wait = 0;
        @(posedge clk_i); #1 rst_ni = 1'b1;
        @(negedge clk_i);
        rem[2] = 1;
        measure(2, gc, rc, rd, er, mr, a1, orv);
        chk("t6_gnt_cycle",    32'(gc), 32'd2);
        chk("t6_rvalid_cycle", 32'(rc), 32'd3);
        chk("t6_rdata",        rd,      32'h1234_5678);

        // 4: all three requesters held high for nine transactions
        @(posedge clk_i); #1 rst_ni = 1'b0;
        @(posedge clk_i); #1 rst_ni = 1'b1;
        order.delete();
        we_cfg = 3'b101;
        @(negedge clk_i);
        for (int k = 0; k < N; k++) rem[k] = 3;
        wait_all(400);
        chk("t4_count", 32'(order.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < order.size()) chk("t4_order", 32'(order[i]), 32'(exp4[i]));
        end

        @(negedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
